fir_result_buf: RTL and testbench
=================================

Name: fir_result_buf

Overview:
Output stage directly downstream of the 3-tap serial-MAC FIR. It captures each completed 15-bit signed FIR result on a one-cycle done strobe, then rounds, shifts and saturates it to 8-bit signed. Converted samples are buffered in a small FIFO and presented to the consumer over a valid/ready handshake, with saturation and drop statistics.

Parameters:
IN_W, 15, width of the signed FIR result input
OUT_W, 8, width of the signed output sample
SHIFT, 4, arithmetic right shift applied after rounding (0 = no shift, no rounding)
DEPTH, 4, FIFO depth in entries (power of 2, >=2)
CNT_W, 8, width of the saturation and drop counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
res_in  in  IN_W  signed FIR result, qualified by res_valid
res_valid  in  1  one-cycle strobe: res_in is final
dout  out  OUT_W  signed converted sample at FIFO head
dout_valid  out  1  FIFO non-empty
dout_ready  in  1  consumer accepts dout this cycle
level  out  log2(DEPTH)+1  current FIFO occupancy
sat_cnt  out  CNT_W  count of results that saturated
drop_cnt  out  CNT_W  count of results lost because the FIFO was full
ovf  out  1  sticky: at least one drop since reset or clear
clr_stat  in  1  synchronous clear of sat_cnt, drop_cnt and ovf

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high. On reset, dout=0, dout_valid=0, level=0, sat_cnt=0, drop_cnt=0, ovf=0, the capture stage is empty and FIFO pointers are 0.
- Conversion, computed at IN_W+1 bits:
  - if SHIFT>0: t = (res_in + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf);
  - if SHIFT=0: t = res_in.
  - If t > 2^(OUT_W-1)-1, output max; if t < -2^(OUT_W-1), output min; either case is a saturation event. Otherwise output t[OUT_W-1:0].
- Stage 1 (capture): at edge k with res_valid=1, register the converted value and set s1_valid; also register the saturation flag. s1_valid clears the next edge unless res_valid=1 again. Back-to-back res_valid is legal every cycle.
- Stage 2 (FIFO write): at the edge after s1_valid, push if not full, or if full and a pop occurs the same edge. Otherwise drop: drop_cnt+1, ovf<=1.
- sat_cnt increments at the stage-1 edge for every saturated result, including results later dropped.
- Latency: res_valid sampled at edge k, FIFO empty -> dout_valid=1 and dout valid after edge k+1.
- Pop: dout_valid && dout_ready at an edge advances the read pointer. dout is the combinational read of the head entry; it is held stable while dout_valid=1 and dout_ready=0. dout=0 when empty.
- Push and pop at the same edge: level unchanged, both succeed, including the full case. Pop when empty is ignored.
- Pointers wrap modulo DEPTH; level = write count minus read count, range 0..DEPTH.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clr_stat has priority over same-cycle increments: counters go to 0 and ovf to 0. clr_stat does not touch FIFO contents or level.
- Reset mid-operation: pending stage-1 sample and all FIFO contents are discarded immediately.

Decomposition:
- Shared package fir_pkg: FIR_RES_W=15, FIR_OUT_W=8, rounding/saturation function sat_round(), level width helper.
- One sub-module: fir_sync_fifo (DEPTH x OUT_W, single clock, async active-high reset, push/pop/full/empty/level). Conversion and statistics stay in fir_result_buf.

Test Plan:
- Rounding, defaults: res_in = 100, -40, 7, 8, -8, -9, one per strobe, dout_ready=1 -> dout = 6, -2, 0, 1, 0, -1 in order; first dout_valid 2 cycles after the first strobe.
- Saturation: res_in = 16383 then -16384 -> dout = 127 then -128, sat_cnt=2, drop_cnt=0.
- Overflow: dout_ready=0, 6 strobes res_in=16,32,...,96 -> level=4, dout=1,2,3,4 on release, drop_cnt=2, ovf=1.
- Full with simultaneous pop: level=4, strobe plus dout_ready=1 at the write edge -> no drop, level stays 4, order preserved.
- Backpressure hold: dout_ready low for 5 cycles with dout_valid=1 -> dout constant. clr_stat pulse concurrent with a drop -> drop_cnt=0, ovf=0.
- Async reset mid-stream: assert rst between clk edges with level=3 -> outputs zero immediately. After release, a fresh strobe res_in=48 -> dout=3.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths and the round/shift/saturate conversion for the FIR output stage.
package fir_pkg;

    localparam int FIR_RES_W = 15;
    localparam int FIR_OUT_W = 8;

    typedef struct packed {
        logic                 sat;
        logic [FIR_OUT_W-1:0] val;
    } conv_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Round half toward +inf, arithmetic shift, then clamp to an out_w-bit signed range.
    function automatic conv_t sat_round(input logic signed [31:0] x, input int shift, input int out_w);
        logic signed [31:0] t;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        conv_t              r;
        if (shift > 0) begin
            t = (x + (32'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            t = x;
        end
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (t > hi) begin
            r.sat = 1'b1;
            r.val = hi[FIR_OUT_W-1:0];
        end else if (t < lo) begin
            r.sat = 1'b1;
            r.val = lo[FIR_OUT_W-1:0];
        end else begin
            r.sat = 1'b0;
            r.val = t[FIR_OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is read combinationally.
module fir_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == {LVL_W{1'b0}});
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? {W{1'b0}} : r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Storage write; contents need no reset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fir_result_buf.sv
// FIR output stage: capture, round/saturate to OUT_W, buffer in a FIFO, and keep
// saturation/drop statistics.
module fir_result_buf
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_RES_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_W-1:0]           res_in,
    input  logic                      res_valid,
    output logic [OUT_W-1:0]          dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic [CNT_W-1:0]          sat_cnt,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      ovf,
    input  logic                      clr_stat
);

    logic signed [31:0] w_res_ext;
    conv_t              w_conv;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_drop;
    logic               r_s1_valid;
    logic [OUT_W-1:0]   r_s1_data;
    logic [CNT_W-1:0]   r_sat_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_ovf;

    assign w_res_ext  = {{(32-IN_W){res_in[IN_W-1]}}, res_in};
    assign w_conv     = sat_round(w_res_ext, SHIFT, OUT_W);
    assign w_pop      = !w_empty && dout_ready;
    assign w_drop     = r_s1_valid && w_full && !w_pop;
    assign dout_valid = !w_empty;
    assign sat_cnt    = r_sat_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign ovf        = r_ovf;

    // Capture stage: holds one converted result for the FIFO write on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {OUT_W{1'b0}};
        end else begin
            r_s1_valid <= res_valid;
            if (res_valid) begin
                r_s1_data <= OUT_W'(w_conv.val);
            end
        end
    end

    // Statistics: clear wins over increments, counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt  <= {CNT_W{1'b0}};
            r_drop_cnt <= {CNT_W{1'b0}};
            r_ovf      <= 1'b0;
        end else if (clr_stat) begin
            r_sat_cnt  <= {CNT_W{1'b0}};
            r_drop_cnt <= {CNT_W{1'b0}};
            r_ovf      <= 1'b0;
        end else begin
            if (res_valid && w_conv.sat && (r_sat_cnt != {CNT_W{1'b1}})) begin
                r_sat_cnt <= r_sat_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != {CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    fir_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W),
        .LVL_W (lvl_w(DEPTH))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s1_valid),
        .i_data  (r_s1_data),
        .i_pop   (w_pop),
        .o_data  (dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

endmodule

// File: tb/tb_fir_result_buf.sv
// Self-checking bench for fir_result_buf: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_fir_result_buf;

    localparam int IN_W  = 15;
    localparam int OUT_W = 8;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LVL_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  res_in;
    logic             res_valid;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] sat_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             ovf;
    logic             clr_stat;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_q[$];
    bit m_pend;
    int m_pend_val;
    int m_sat;
    int m_drop;
    bit m_ovf;

    typedef struct {
        int res;
        int exp_d;
        bit exp_sat;
    } vec_t;
    vec_t vecs[10];

    int rnd_seq[6];
    int rnd_exp[6];

    always #5 clk = ~clk;

    fir_result_buf dut (
        .clk        (clk),
        .rst        (rst),
        .res_in     (res_in),
        .res_valid  (res_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .sat_cnt    (sat_cnt),
        .drop_cnt   (drop_cnt),
        .ovf        (ovf),
        .clr_stat   (clr_stat)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division written out explicitly, then clamp.
    function automatic int model_conv(input int x, output bit sat);
        int num;
        int q;
        int lim;
        lim = 1 << (OUT_W - 1);
        if (SHIFT == 0) begin
            q = x;
        end else begin
            num = x + (1 << (SHIFT - 1));
            q   = num / (1 << SHIFT);
            if ((num % (1 << SHIFT)) != 0 && num < 0) q = q - 1;
        end
        sat = (q > lim - 1) || (q < -lim);
        if (q > lim - 1) q = lim - 1;
        else if (q < -lim) q = -lim;
        return q;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend = 1'b0;
        m_pend_val = 0;
        m_sat = 0;
        m_drop = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit rv, input int x, input bit rdy, input bit clr);
        bit s;
        int v;
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (m_pend) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pend_val);
            else begin
                if (m_drop < CMAX) m_drop++;
                m_ovf = 1'b1;
            end
        end
        v = model_conv(x, s);
        if (rv && s && m_sat < CMAX) m_sat++;
        if (clr) begin
            m_sat = 0;
            m_drop = 0;
            m_ovf = 1'b0;
        end
        m_pend = rv;
        m_pend_val = v;
    endtask

    task automatic compare_all();
        check("dout_valid", int'(dout_valid), (m_q.size() > 0) ? 1 : 0);
        check("dout", int'($signed(dout)), (m_q.size() > 0) ? m_q[0] : 0);
        check("level", int'(level), m_q.size());
        check("sat_cnt", int'(sat_cnt), m_sat);
        check("drop_cnt", int'(drop_cnt), m_drop);
        check("ovf", int'(ovf), int'(m_ovf));
    endtask

    task automatic step(input bit rv, input int x, input bit rdy, input bit clr);
        res_valid  = rv;
        res_in     = IN_W'(x);
        dout_ready = rdy;
        clr_stat   = clr;
        @(posedge clk);
        model_step(rv, x, rdy, clr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        res_valid = 1'b0;
        res_in = '0;
        dout_ready = 1'b0;
        clr_stat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{100, 6, 1'b0};
        vecs[1] = '{-40, -2, 1'b0};
        vecs[2] = '{7, 0, 1'b0};
        vecs[3] = '{8, 1, 1'b0};
        vecs[4] = '{-8, 0, 1'b0};
        vecs[5] = '{-9, -1, 1'b0};
        vecs[6] = '{16383, 127, 1'b1};
        vecs[7] = '{-16384, -128, 1'b1};
        vecs[8] = '{2039, 127, 1'b0};
        vecs[9] = '{2040, 127, 1'b1};
        rnd_seq = '{100, -40, 7, 8, -8, -9};
        rnd_exp = '{6, -2, 0, 1, 0, -1};

        do_reset();
        check("reset_dout", int'(dout), 0);
        check("reset_level", int'(level), 0);

        // Conversion vectors, one at a time through an empty FIFO
        for (int i = 0; i < 10; i++) begin
            int sat_before;
            sat_before = m_sat;
            step(1'b1, vecs[i].res, 1'b1, 1'b0);
            check("tbl_not_yet_valid", int'(dout_valid), 0);
            step(1'b0, 0, 1'b0, 1'b0);
            check("tbl_dout", int'($signed(dout)), vecs[i].exp_d);
            check("tbl_sat", int'(sat_cnt), sat_before + int'(vecs[i].exp_sat));
            step(1'b0, 0, 1'b1, 1'b0);
        end

        // Back-to-back rounding stream with the consumer always ready
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rnd_seq[i], 1'b1, 1'b0);
            if (i == 0) check("seq_latency", int'(dout_valid), 0);
            else check("seq_dout", int'($signed(dout)), rnd_exp[i-1]);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        check("seq_dout_last", int'($signed(dout)), rnd_exp[5]);
        step(1'b0, 0, 1'b1, 1'b0);

        // Saturation pair
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b1, 16383, 1'b1, 1'b0);
        step(1'b1, -16384, 1'b1, 1'b0);
        check("sat_hi", int'($signed(dout)), 127);
        step(1'b0, 0, 1'b1, 1'b0);
        check("sat_lo", int'($signed(dout)), -128);
        check("sat_cnt2", int'(sat_cnt), 2);
        check("sat_drop0", int'(drop_cnt), 0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Overflow: six strobes into a stalled FIFO
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) step(1'b1, 16 * i, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        check("ovf_level", int'(level), 4);
        check("ovf_drop", int'(drop_cnt), 2);
        check("ovf_flag", int'(ovf), 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order", int'($signed(dout)), i);
            step(1'b0, 0, 1'b1, 1'b0);
        end
        check("ovf_empty", int'(level), 0);

        // Full FIFO with a pop on the write edge
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, 16 * i, 1'b0, 1'b0);
        step(1'b1, 80, 1'b0, 1'b0);
        check("full_level_pre", int'(level), 4);
        step(1'b0, 0, 1'b1, 1'b0);
        check("full_level_kept", int'(level), 4);
        check("full_no_drop", int'(drop_cnt), 0);
        for (int i = 2; i <= 5; i++) begin
            check("full_order", int'($signed(dout)), i);
            step(1'b0, 0, 1'b1, 1'b0);
        end

        // Backpressure hold, and clear coinciding with a drop
        for (int i = 1; i <= 4; i++) step(1'b1, 16 * i, 1'b0, 1'b0);
        step(1'b1, 32, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        check("clr_drop", int'(drop_cnt), 0);
        check("clr_ovf", int'(ovf), 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 1'b0, 1'b0);
            check("hold_dout", int'($signed(dout)), 1);
        end
        step(1'b0, 0, 1'b1, 1'b0);
        check("pre_rst_level", int'(level), 3);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_valid", int'(dout_valid), 0);
        check("arst_level", int'(level), 0);
        check("arst_dout", int'(dout), 0);
        compare_all();
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 48, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        check("arst_fresh", int'($signed(dout)), 3);
        step(1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int x;
            if ($urandom_range(0, 1) == 0) x = $urandom_range(0, 4095) - 2048;
            else x = $urandom_range(0, 32767) - 16384;
            step($urandom_range(0, 9) < 7, x, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
